// File: rtl/spu_boot_loader.sv
// Boot-time loader: decodes a 32-bit header/payload word stream into IMEM, RF and LS preload
// strobes, holding the core in reset until a GO header arrives.
module spu_boot_loader #(
    parameter int IMEM_AW = 10,
    parameter int RF_AW   = 10,
    parameter int LS_AW   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:31]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 load_en,
    output logic [0:IMEM_AW-1]   instr_load_addr,
    output logic [0:31]          instruction_in,
    output logic                 preload_en,
    output logic [0:RF_AW-1]     preload_addr,
    output logic [0:127]         preload_values,
    output logic                 preload_LS_en,
    output logic [0:LS_AW-1]     preload_LS_addr,
    output logic [0:127]         preload_LS_data,
    output logic                 core_rst,
    output logic                 running,
    output logic [1:0]           state_dbg_o
);

    typedef enum logic [1:0] {S_IDLE, S_IMEM, S_QUAD, S_RUN} state_e;

    localparam logic [14:0] IMEM_MASK = 15'((32'd1 << IMEM_AW) - 32'd1);
    localparam logic [14:0] RF_MASK   = 15'((32'd1 << RF_AW) - 32'd1);
    localparam logic [14:0] LS_MASK   = 15'((32'd1 << LS_AW) - 32'd1);

    // Handshake: a word transfers on a rising clk edge where in_valid & in_ready are both 1;
    // in_valid may drop at any time and in_ready never depends on in_valid.
    state_e state_q, state_d;
    logic        init_q;
    logic [14:0] addr_q, addr_d;
    logic [14:0] cnt_q, cnt_d;
    logic        is_ls_q, is_ls_d;
    logic [1:0]  widx_q, widx_d;
    logic [0:95] quad_q, quad_d;

    logic                load_en_q, load_en_d;
    logic [0:IMEM_AW-1]  imem_addr_q, imem_addr_d;
    logic [0:31]         instr_q, instr_d;
    logic                rf_en_q, rf_en_d;
    logic [0:RF_AW-1]    rf_addr_q, rf_addr_d;
    logic [0:127]        rf_data_q, rf_data_d;
    logic                ls_en_q, ls_en_d;
    logic [0:LS_AW-1]    ls_addr_q, ls_addr_d;
    logic [0:127]        ls_data_q, ls_data_d;
    logic                core_rst_q, core_rst_d;
    logic                running_q, running_d;

    logic        accept;
    logic [14:0] cur_mask;
    logic [14:0] addr_inc;
    logic [1:0]  hdr_tgt;
    logic [14:0] hdr_addr;
    logic [14:0] hdr_cnt;

    assign in_ready = init_q && (state_q != S_RUN);
    assign accept   = in_valid && in_ready;
    assign hdr_tgt  = in_data[0:1];
    assign hdr_addr = in_data[2:16];
    assign hdr_cnt  = in_data[17:31];
    assign cur_mask = (state_q == S_IMEM) ? IMEM_MASK : (is_ls_q ? LS_MASK : RF_MASK);
    assign addr_inc = (addr_q + 15'd1) & cur_mask;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        is_ls_d     = is_ls_q;
        widx_d      = widx_q;
        quad_d      = quad_q;
        load_en_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        instr_d     = instr_q;
        rf_en_d     = 1'b0;
        rf_addr_d   = rf_addr_q;
        rf_data_d   = rf_data_q;
        ls_en_d     = 1'b0;
        ls_addr_d   = ls_addr_q;
        ls_data_d   = ls_data_q;
        core_rst_d  = core_rst_q;
        running_d   = running_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d  = hdr_cnt;
                    widx_d = 2'd0;
                    case (hdr_tgt)
                        2'b00: begin
                            state_d = S_IMEM;
                            addr_d  = hdr_addr & IMEM_MASK;
                        end
                        2'b01: begin
                            state_d = S_QUAD;
                            is_ls_d = 1'b0;
                            addr_d  = hdr_addr & RF_MASK;
                        end
                        2'b10: begin
                            state_d = S_QUAD;
                            is_ls_d = 1'b1;
                            addr_d  = hdr_addr & LS_MASK;
                        end
                        default: begin
                            state_d    = S_RUN;
                            core_rst_d = 1'b0;
                            running_d  = 1'b1;
                        end
                    endcase
                end
            end
            S_IMEM: begin
                if (accept) begin
                    load_en_d   = 1'b1;
                    imem_addr_d = addr_q[IMEM_AW-1:0];
                    instr_d     = in_data;
                    addr_d      = addr_inc;
                    if (cnt_q == 15'd0) state_d = S_IDLE;
                    else                cnt_d   = cnt_q - 15'd1;
                end
            end
            S_QUAD: begin
                if (accept) begin
                    // Words 0..2 are staged; word 3 completes the quadword and issues the write.
                    case (widx_q)
                        2'd0: quad_d[0:31]  = in_data;
                        2'd1: quad_d[32:63] = in_data;
                        2'd2: quad_d[64:95] = in_data;
                        default: begin
                            if (is_ls_q) begin
                                ls_en_d   = 1'b1;
                                ls_addr_d = addr_q[LS_AW-1:0];
                                ls_data_d = {quad_q, in_data};
                            end else begin
                                rf_en_d   = 1'b1;
                                rf_addr_d = addr_q[RF_AW-1:0];
                                rf_data_d = {quad_q, in_data};
                            end
                            addr_d = addr_inc;
                            if (cnt_q == 15'd0) state_d = S_IDLE;
                            else                cnt_d   = cnt_q - 15'd1;
                        end
                    endcase
                    widx_d = widx_q + 2'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            init_q      <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            is_ls_q     <= 1'b0;
            widx_q      <= '0;
            quad_q      <= '0;
            load_en_q   <= 1'b0;
            imem_addr_q <= '0;
            instr_q     <= '0;
            rf_en_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_data_q   <= '0;
            ls_en_q     <= 1'b0;
            ls_addr_q   <= '0;
            ls_data_q   <= '0;
            core_rst_q  <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= 1'b1;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            is_ls_q     <= is_ls_d;
            widx_q      <= widx_d;
            quad_q      <= quad_d;
            load_en_q   <= load_en_d;
            imem_addr_q <= imem_addr_d;
            instr_q     <= instr_d;
            rf_en_q     <= rf_en_d;
            rf_addr_q   <= rf_addr_d;
            rf_data_q   <= rf_data_d;
            ls_en_q     <= ls_en_d;
            ls_addr_q   <= ls_addr_d;
            ls_data_q   <= ls_data_d;
            core_rst_q  <= core_rst_d;
            running_q   <= running_d;
        end
    end

    assign load_en         = load_en_q;
    assign instr_load_addr = imem_addr_q;
    assign instruction_in  = instr_q;
    assign preload_en      = rf_en_q;
    assign preload_addr    = rf_addr_q;
    assign preload_values  = rf_data_q;
    assign preload_LS_en   = ls_en_q;
    assign preload_LS_addr = ls_addr_q;
    assign preload_LS_data = ls_data_q;
    assign core_rst        = core_rst_q;
    assign running         = running_q;
    assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_spu_boot_loader.sv
// Directed vector bench for spu_boot_loader: table of {input word, expected strobe/addr/data}
// plus hand-written reset and GO sequences.
module tb_spu_boot_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:31]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          load_en;
    logic [0:9]    instr_load_addr;
    logic [0:31]   instruction_in;
    logic          preload_en;
    logic [0:9]    preload_addr;
    logic [0:127]  preload_values;
    logic          preload_LS_en;
    logic [0:14]   preload_LS_addr;
    logic [0:127]  preload_LS_data;
    logic          core_rst;
    logic          running;
    logic [1:0]    state_dbg;

    spu_boot_loader #(.IMEM_AW(10), .RF_AW(10), .LS_AW(15)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .load_en(load_en), .instr_load_addr(instr_load_addr), .instruction_in(instruction_in),
        .preload_en(preload_en), .preload_addr(preload_addr), .preload_values(preload_values),
        .preload_LS_en(preload_LS_en), .preload_LS_addr(preload_LS_addr),
        .preload_LS_data(preload_LS_data), .core_rst(core_rst), .running(running),
        .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    // kind: 0 no write, 1 IMEM, 2 RF, 3 LS
    typedef struct {
        logic         vld;
        logic [31:0]  data;
        logic         rdy;
        logic [1:0]   kind;
        logic [14:0]  addr;
        logic [127:0] wdata;
        logic         crst;
        logic         run;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [31:0] hdr(logic [1:0] t, logic [14:0] a, logic [14:0] c);
        return {t, a, c};
    endfunction

    function automatic void add(logic vld, logic [31:0] data, logic rdy, logic [1:0] kind,
                                logic [14:0] addr, logic [127:0] wdata, logic crst, logic run);
        vec_t v;
        v.vld = vld; v.data = data; v.rdy = rdy; v.kind = kind;
        v.addr = addr; v.wdata = wdata; v.crst = crst; v.run = run;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        in_valid = v.vld;
        in_data  = v.data;
        #1;
        chk({tag, "/in_ready"}, 128'(in_ready), 128'(v.rdy));
        @(posedge clk);
        #1;
        chk({tag, "/load_en"}, 128'(load_en), 128'(v.kind == 2'd1));
        chk({tag, "/preload_en"}, 128'(preload_en), 128'(v.kind == 2'd2));
        chk({tag, "/preload_LS_en"}, 128'(preload_LS_en), 128'(v.kind == 2'd3));
        chk({tag, "/core_rst"}, 128'(core_rst), 128'(v.crst));
        chk({tag, "/running"}, 128'(running), 128'(v.run));
        case (v.kind)
            2'd1: begin
                chk({tag, "/imem_addr"}, 128'(instr_load_addr), 128'(v.addr[9:0]));
                chk({tag, "/imem_data"}, 128'(instruction_in), 128'(v.wdata[31:0]));
            end
            2'd2: begin
                chk({tag, "/rf_addr"}, 128'(preload_addr), 128'(v.addr[9:0]));
                chk({tag, "/rf_data"}, preload_values, v.wdata);
            end
            2'd3: begin
                chk({tag, "/ls_addr"}, 128'(preload_LS_addr), 128'(v.addr));
                chk({tag, "/ls_data"}, preload_LS_data, v.wdata);
            end
            default: begin
            end
        endcase
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "/load_en"}, 128'(load_en), 128'(0));
        chk({tag, "/preload_en"}, 128'(preload_en), 128'(0));
        chk({tag, "/preload_LS_en"}, 128'(preload_LS_en), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // ---- reset state ----
        #2;
        chk("rst/in_ready", 128'(in_ready), 128'(0));
        chk("rst/core_rst", 128'(core_rst), 128'(1));
        chk("rst/running", 128'(running), 128'(0));
        check_quiet("rst");
        chk("rst/imem_addr", 128'(instr_load_addr), 128'(0));
        chk("rst/ls_data", preload_LS_data, 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel/in_ready_before_clk", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("rel/in_ready_after_clk", 128'(in_ready), 128'(1));

        // ---- vector table ----
        // IMEM addr 0, 3 items back-to-back
        add(1, hdr(2'b00, 15'd0, 15'd2), 1, 0, 0, 0, 1, 0);
        add(1, 32'hA0000001, 1, 1, 15'd0, 128'(32'hA0000001), 1, 0);
        add(1, 32'hA0000002, 1, 1, 15'd1, 128'(32'hA0000002), 1, 0);
        add(1, 32'hA0000003, 1, 1, 15'd2, 128'(32'hA0000003), 1, 0);
        // LS addr 1, 2 items
        add(1, hdr(2'b10, 15'd1, 15'd1), 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000001, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000001, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000001, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000001, 1, 3, 15'd1, {4{32'h00000001}}, 1, 0);
        add(1, 32'h00000002, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000002, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000002, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000002, 1, 3, 15'd2, {4{32'h00000002}}, 1, 0);
        // RF addr 5, 1 item, with valid gaps
        add(1, hdr(2'b01, 15'd5, 15'd0), 1, 0, 0, 0, 1, 0);
        add(1, 32'hDEAD0001, 1, 0, 0, 0, 1, 0);
        add(0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0);
        add(1, 32'hDEAD0002, 1, 0, 0, 0, 1, 0);
        add(0, 32'h12345678, 1, 0, 0, 0, 1, 0);
        add(0, 32'h12345678, 1, 0, 0, 0, 1, 0);
        add(1, 32'hDEAD0003, 1, 0, 0, 0, 1, 0);
        add(1, 32'hDEAD0004, 1, 2, 15'd5,
            {32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004}, 1, 0);
        // IMEM addr 1023, 2 items: wraps to 0
        add(1, hdr(2'b00, 15'd1023, 15'd1), 1, 0, 0, 0, 1, 0);
        add(1, 32'h11111111, 1, 1, 15'd1023, 128'(32'h11111111), 1, 0);
        add(1, 32'h22222222, 1, 1, 15'd0, 128'(32'h22222222), 1, 0);
        // IMEM header address beyond IMEM width is truncated (2049 -> 1)
        add(1, hdr(2'b00, 15'd2049, 15'd0), 1, 0, 0, 0, 1, 0);
        add(1, 32'h33333333, 1, 1, 15'd1, 128'(32'h33333333), 1, 0);
        // GO, then ignored words
        add(1, hdr(2'b11, 15'd0, 15'd7), 1, 0, 0, 0, 0, 1);
        add(1, hdr(2'b00, 15'd0, 15'd0), 0, 0, 0, 0, 0, 1);
        add(1, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 1);
        add(1, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // ---- async reset leaves RUN ----
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_run/core_rst", 128'(core_rst), 128'(1));
        chk("rst_run/running", 128'(running), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- rst in the middle of an LS quad ----
        tbl.delete();
        add(1, hdr(2'b10, 15'd7, 15'd0), 1, 0, 0, 0, 1, 0);
        add(1, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0);
        add(1, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("part%0d", i));
        end
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst/core_rst", 128'(core_rst), 128'(1));
        chk("midrst/in_ready", 128'(in_ready), 128'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_quiet($sformatf("midrst%0d", i));
        end
        chk("midrst/ls_data", preload_LS_data, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("postrst");

        tbl.delete();
        add(1, hdr(2'b10, 15'd3, 15'd0), 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000005, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000006, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000007, 1, 0, 0, 0, 1, 0);
        add(1, 32'h00000008, 1, 3, 15'd3,
            {32'h00000005, 32'h00000006, 32'h00000007, 32'h00000008}, 1, 0);
        add(0, 32'h00000000, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("fresh%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
